match_scan_sequencer: RTL and testbench
=======================================

MATCH_SCAN_SEQUENCER -- requirements
Module: match_scan_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: read address width and scan-length width.
REQ-002 Parameter DATA_W, default 8: data, pattern and mask width.
REQ-003 Parameter CNT_W, default 8: match counter and limit width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled low at a rising clk edge = reset.
REQ-006 start  input  1  begin a scan; sampled only in IDLE.
REQ-007 abort  input  1  terminate an active scan.
REQ-008 base_addr  input  ADDR_W  first word address; latched at start.
REQ-009 length  input  ADDR_W  number of words to scan; latched at start; 0 = empty scan.
REQ-010 pattern / mask  input  DATA_W each  compare value and bit mask; latched at start.
REQ-011 match_limit  input  CNT_W  stop after this many matches; 0 = no limit; latched at start.
REQ-012 rd_req  output  1  read request, held until accepted.
REQ-013 rd_addr  output  ADDR_W  read address, valid while rd_req=1.
REQ-014 rd_ready  input  1  memory accepts request when rd_req & rd_ready.
REQ-015 rd_valid / rd_data  input  1 / DATA_W  read response.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at scan end.
REQ-018 halted  output  1  scan ended by match_limit; held until next accepted start.
REQ-019 match_flag  output  1  one-cycle pulse per matching word.
REQ-020 match_count  output  CNT_W  matches in current/last scan; held after done until next start.
REQ-021 state  output  3  encoding: IDLE=000, REQ=001, WAIT=010, CMP=011, DONE=100.

Function
REQ-022 IDLE: start=1 -> latch config, match_count=0, halted=0, addr=base_addr, remaining=length; next REQ, or DONE if length=0.
REQ-023 REQ: rd_req=1, rd_addr=addr; rd_ready=1 -> WAIT; rd_req and rd_addr stable while rd_ready=0.
REQ-024 WAIT: rd_req=0; rd_valid=1 -> capture rd_data, -> CMP; rd_valid outside WAIT is ignored.
REQ-025 CMP: match when (data & mask) == (pattern & mask); on match match_flag=1 next cycle and match_count increments, saturating at 2^CNT_W-1.
REQ-026 CMP exit, priority order: match with limit!=0 and new count==match_limit -> halted=1, DONE; remaining==1 -> DONE; else addr+1 (modulo 2^ADDR_W), remaining-1, -> REQ.
REQ-027 DONE lasts exactly one cycle with done=1, then IDLE; start during DONE is ignored.
REQ-028 start while busy=1 is ignored; latched config does not change mid-scan.
REQ-029 abort in REQ with rd_ready=0 -> DONE next cycle, no transfer.
REQ-030 abort in REQ with rd_ready=1, or in WAIT -> set abort-pending; drain response in WAIT, then DONE without compare; match_count unchanged.
REQ-031 abort in CMP -> compare of current word completes and counts; next state DONE; abort in IDLE/DONE ignored.
REQ-032 Aborted scans assert done and leave halted=0.
REQ-033 Throughput: with rd_ready and rd_valid both 1 at first opportunity, one word per 3 cycles (REQ, WAIT, CMP).

Reset
REQ-034 reset=0 at a rising edge, in any state: state=IDLE, rd_req=0, rd_addr=0, busy=0, done=0, halted=0, match_flag=0, match_count=0, abort-pending cleared.
REQ-035 An outstanding read is abandoned on reset; a later rd_valid in IDLE is ignored.

Verification
REQ-036 base=0x10, len=4, pattern=0xA5, mask=0xFF, limit=0, data A5,00,A5,A5, ready/valid immediate -> rd_addr 10,11,12,13; three match_flag pulses; match_count=3; done once; halted=0.
REQ-037 Same as REQ-036 with limit=2 -> reads 10,11,12 only; match_count=2; halted=1; done once; no fourth rd_req.
REQ-038 len=0, start at cycle t -> state DONE with done=1 at t+1, IDLE at t+2, no rd_req, match_count=0.
REQ-039 base=0xFE, len=3, rd_ready low 2 cycles per request -> rd_addr FE,FF,00 each held stable until accepted.
REQ-040 pattern=0x05, mask=0x0F, data 0xF5 then abort asserted in WAIT of second read -> first word matches (count=1), second response drained, no compare, done, count=1, halted=0.
REQ-041 reset low in WAIT mid-scan with count=2 -> next edge all outputs at reset values; subsequent stray rd_valid ignored; new start runs normally.

Source files
------------

// File: rtl/match_scan_sequencer.sv
// Scans a window of memory words, counting words that match a masked pattern.
// Supports an optional match limit and a clean abort that drains outstanding reads.
module match_scan_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] mask,
    input  logic [CNT_W-1:0]  match_limit,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              match_flag,
    output logic [CNT_W-1:0]  match_count,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_REQ  = 3'b001,
        S_WAIT = 3'b010,
        S_CMP  = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t            st;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] msk_q;
    logic [CNT_W-1:0]  limit_q;
    logic [DATA_W-1:0] data_q;
    logic              abort_pend;

    logic              is_match;
    logic [CNT_W-1:0]  cnt_inc;
    logic              limit_hit;
    logic              last_word;

    assign state     = st;
    assign is_match  = (data_q & msk_q) == (pat_q & msk_q);
    assign cnt_inc   = (match_count == '1) ? match_count
                                           : match_count + CNT_W'(1);
    assign limit_hit = is_match && (limit_q != '0)
                       && (cnt_inc == limit_q);
    assign last_word = remaining == ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            st          <= S_IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            match_flag  <= 1'b0;
            match_count <= '0;
            remaining   <= '0;
            pat_q       <= '0;
            msk_q       <= '0;
            limit_q     <= '0;
            data_q      <= '0;
            abort_pend  <= 1'b0;
        end else begin
            done       <= 1'b0;
            match_flag <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        msk_q       <= mask;
                        limit_q     <= match_limit;
                        match_count <= '0;
                        halted      <= 1'b0;
                        rd_addr     <= base_addr;
                        remaining   <= length;
                        abort_pend  <= 1'b0;
                        busy        <= 1'b1;
                        if (length == '0) begin
                            st   <= S_DONE;
                            done <= 1'b1;
                        end else begin
                            st     <= S_REQ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (rd_ready) begin
                        rd_req <= 1'b0;
                        st     <= S_WAIT;
                        if (abort) abort_pend <= 1'b1;
                    end else if (abort) begin
                        rd_req <= 1'b0;
                        st     <= S_DONE;
                        done   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // An aborted scan still consumes its in-flight response
                    if (rd_valid) begin
                        data_q <= rd_data;
                        if (abort || abort_pend) begin
                            st   <= S_DONE;
                            done <= 1'b1;
                        end else begin
                            st <= S_CMP;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                S_CMP: begin
                    if (is_match) begin
                        match_flag  <= 1'b1;
                        match_count <= cnt_inc;
                    end
                    unique case (1'b1)
                        limit_hit: begin
                            halted <= 1'b1;
                            st     <= S_DONE;
                            done   <= 1'b1;
                        end
                        !limit_hit && (last_word || abort): begin
                            st   <= S_DONE;
                            done <= 1'b1;
                        end
                        !limit_hit && !last_word && !abort: begin
                            rd_addr   <= rd_addr + ADDR_W'(1);
                            remaining <= remaining - ADDR_W'(1);
                            rd_req    <= 1'b1;
                            st        <= S_REQ;
                        end
                        default: st <= S_DONE;
                    endcase
                end
                S_DONE: begin
                    st         <= S_IDLE;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                end
                default: begin
                    st     <= S_IDLE;
                    busy   <= 1'b0;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_scan_sequencer.sv
// Directed bench for match_scan_sequencer with a simple memory responder.
// Responder grants after ready_delay stalls and answers after valid_delay.
module tb_match_scan_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic [7:0] pattern;
    logic [7:0] mask;
    logic [7:0] match_limit;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       halted;
    logic       match_flag;
    logic [7:0] match_count;
    logic [2:0] state;

    int compared;
    int mismatched;

    logic [7:0] mem [256];
    logic [7:0] acc_q [$];
    int ready_delay;
    int valid_delay;
    int n_match, n_done, n_req, n_busy, unstable;
    bit stalling, vpend;
    int scnt, vcnt;
    logic [7:0] stall_addr, vaddr;

    match_scan_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .pattern(pattern), .mask(mask), .match_limit(match_limit),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .halted(halted),
        .match_flag(match_flag), .match_count(match_count),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder and output monitor, active on the falling edge
    initial begin
        rd_ready = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        stalling = 1'b0;
        vpend    = 1'b0;
        scnt = 0;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (match_flag === 1'b1) n_match++;
            if (done === 1'b1) n_done++;
            if (rd_req === 1'b1) n_req++;
            if (busy === 1'b1) n_busy++;
            rd_valid = 1'b0;
            if (rd_ready) begin
                rd_ready = 1'b0;
                vpend = 1'b1;
                vcnt = 0;
            end else if (rd_req === 1'b1) begin
                if (!stalling) begin
                    stall_addr = rd_addr;
                    stalling = 1'b1;
                    scnt = 0;
                end else if (rd_addr !== stall_addr) begin
                    unstable++;
                end
                if (scnt >= ready_delay) begin
                    rd_ready = 1'b1;
                    acc_q.push_back(rd_addr);
                    vaddr = rd_addr;
                    stalling = 1'b0;
                end else begin
                    scnt++;
                end
            end else begin
                stalling = 1'b0;
            end
            if (vpend) begin
                if (vcnt >= valid_delay) begin
                    rd_valid = 1'b1;
                    rd_data = mem[vaddr];
                    vpend = 1'b0;
                end else begin
                    vcnt++;
                end
            end
        end
    end

    task automatic clear_mon();
        n_match = 0;
        n_done = 0;
        n_req = 0;
        n_busy = 0;
        unstable = 0;
        acc_q.delete();
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] l,
                            input logic [7:0] p, input logic [7:0] m,
                            input logic [7:0] lim);
        @(negedge clk);
        base_addr = b;
        length = l;
        pattern = p;
        mask = m;
        match_limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_timeout: busy=%b want 0", name, busy);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (state !== 3'b000) begin
            $display("FAIL rst_state: got %b want 000", state);
            mismatched++;
        end
        compared++;
        if ({rd_req, busy, done, halted, match_flag} !== 5'b0) begin
            $display("FAIL rst_flags: got %b want 00000",
                     {rd_req, busy, done, halted, match_flag});
            mismatched++;
        end
        compared++;
        if (rd_addr !== 8'h00 || match_count !== 8'h00) begin
            $display("FAIL rst_regs: addr=%h cnt=%h want 00 00",
                     rd_addr, match_count);
            mismatched++;
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] ea [4];
        ea = '{8'h10, 8'h11, 8'h12, 8'h13};
        clear_mon();
        do_start(8'h10, 8'd4, 8'hA5, 8'hFF, 8'd0);
        wait_idle(100, "basic");
        compared++;
        if (acc_q.size() != 4) begin
            $display("FAIL basic_nreads: got %0d want 4", acc_q.size());
            mismatched++;
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (acc_q[i] !== ea[i]) begin
                $display("FAIL basic_addr%0d: got %h want %h",
                         i, acc_q[i], ea[i]);
                mismatched++;
            end
        end
        compared++;
        if (n_match != 3 || match_count !== 8'd3) begin
            $display("FAIL basic_count: pulses=%0d cnt=%0d want 3 3",
                     n_match, match_count);
            mismatched++;
        end
        compared++;
        if (n_done != 1 || halted !== 1'b0) begin
            $display("FAIL basic_end: done=%0d halted=%b want 1 0",
                     n_done, halted);
            mismatched++;
        end
        compared++;
        if (n_busy != 13) begin
            $display("FAIL basic_cycles: got %0d want 13", n_busy);
            mismatched++;
        end
    endtask

    task automatic test_limit();
        clear_mon();
        do_start(8'h10, 8'd4, 8'hA5, 8'hFF, 8'd2);
        wait_idle(100, "limit");
        repeat (3) @(negedge clk);
        compared++;
        if (acc_q.size() != 3 || n_req != 3) begin
            $display("FAIL limit_reads: got %0d/%0d want 3/3",
                     acc_q.size(), n_req);
            mismatched++;
        end
        compared++;
        if (acc_q[2] !== 8'h12) begin
            $display("FAIL limit_last: got %h want 12", acc_q[2]);
            mismatched++;
        end
        compared++;
        if (match_count !== 8'd2 || halted !== 1'b1) begin
            $display("FAIL limit_end: cnt=%0d halted=%b want 2 1",
                     match_count, halted);
            mismatched++;
        end
        compared++;
        if (n_done != 1 || n_busy != 10) begin
            $display("FAIL limit_pulse: done=%0d busy=%0d want 1 10",
                     n_done, n_busy);
            mismatched++;
        end
    endtask

    task automatic test_empty();
        clear_mon();
        do_start(8'h30, 8'd0, 8'h00, 8'h00, 8'd0);
        compared++;
        if (state !== 3'b100 || done !== 1'b1) begin
            $display("FAIL empty_t1: state=%b done=%b want 100 1",
                     state, done);
            mismatched++;
        end
        @(negedge clk);
        compared++;
        if (state !== 3'b000 || done !== 1'b0) begin
            $display("FAIL empty_t2: state=%b done=%b want 000 0",
                     state, done);
            mismatched++;
        end
        compared++;
        if (n_req != 0 || match_count !== 8'd0 || halted !== 1'b0) begin
            $display("FAIL empty_end: req=%0d cnt=%0d halted=%b want 0 0 0",
                     n_req, match_count, halted);
            mismatched++;
        end
    endtask

    task automatic test_wrap_stall();
        logic [7:0] ea [3];
        ea = '{8'hFE, 8'hFF, 8'h00};
        mem[8'hFE] = 8'h3C;
        mem[8'hFF] = 8'h3C;
        mem[8'h00] = 8'h11;
        ready_delay = 2;
        clear_mon();
        do_start(8'hFE, 8'd3, 8'h3C, 8'hF0, 8'd0);
        wait_idle(100, "wrap");
        ready_delay = 0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (acc_q[i] !== ea[i]) begin
                $display("FAIL wrap_addr%0d: got %h want %h",
                         i, acc_q[i], ea[i]);
                mismatched++;
            end
        end
        compared++;
        if (unstable != 0 || n_req != 9) begin
            $display("FAIL wrap_hold: changes=%0d req=%0d want 0 9",
                     unstable, n_req);
            mismatched++;
        end
        compared++;
        if (match_count !== 8'd2) begin
            $display("FAIL wrap_count: got %0d want 2", match_count);
            mismatched++;
        end
    endtask

    task automatic test_abort();
        int n;
        ready_delay = 3;
        clear_mon();
        do_start(8'h40, 8'd2, 8'h00, 8'h00, 8'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (state !== 3'b100 || done !== 1'b1) begin
            $display("FAIL abort_req: state=%b done=%b want 100 1",
                     state, done);
            mismatched++;
        end
        wait_idle(20, "abort_req");
        ready_delay = 0;
        compared++;
        if (acc_q.size() != 0 || match_count !== 8'd0) begin
            $display("FAIL abort_req_xfer: reads=%0d cnt=%0d want 0 0",
                     acc_q.size(), match_count);
            mismatched++;
        end

        mem[8'h20] = 8'hF5;
        mem[8'h21] = 8'hF5;
        valid_delay = 2;
        clear_mon();
        do_start(8'h20, 8'd4, 8'h05, 8'h0F, 8'd0);
        n = 0;
        while (!(state === 3'b010 && acc_q.size() == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (state !== 3'b010) begin
            $display("FAIL abort_reach_wait: state=%b want 010", state);
            mismatched++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (state !== 3'b010) begin
            $display("FAIL abort_drain: state=%b want 010", state);
            mismatched++;
        end
        wait_idle(50, "abort");
        valid_delay = 0;
        compared++;
        if (match_count !== 8'd1 || n_match != 1) begin
            $display("FAIL abort_count: cnt=%0d pulses=%0d want 1 1",
                     match_count, n_match);
            mismatched++;
        end
        compared++;
        if (n_done != 1 || halted !== 1'b0 || acc_q.size() != 2) begin
            $display("FAIL abort_end: done=%0d halted=%b reads=%0d want 1 0 2",
                     n_done, halted, acc_q.size());
            mismatched++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        valid_delay = 2;
        clear_mon();
        do_start(8'h10, 8'd4, 8'hA5, 8'hFF, 8'd0);
        n = 0;
        while (!(state === 3'b010 && acc_q.size() == 4) && n < 80) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (match_count !== 8'd2 || state !== 3'b010) begin
            $display("FAIL rmid_pre: cnt=%0d state=%b want 2 010",
                     match_count, state);
            mismatched++;
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({state, rd_req, busy, done, halted, match_flag} !== 8'b0
            || rd_addr !== 8'h00 || match_count !== 8'h00) begin
            $display("FAIL rmid_rst: st=%b flags=%b addr=%h cnt=%h want 0",
                     state, {rd_req, busy, done, halted, match_flag},
                     rd_addr, match_count);
            mismatched++;
        end
        reset = 1'b1;
        clear_mon();
        repeat (6) @(negedge clk);
        compared++;
        if (state !== 3'b000 || n_match != 0 || match_count !== 8'd0
            || busy !== 1'b0) begin
            $display("FAIL rmid_stray: st=%b pulses=%0d cnt=%0d want 000 0 0",
                     state, n_match, match_count);
            mismatched++;
        end
        valid_delay = 0;
        clear_mon();
        do_start(8'h10, 8'd4, 8'hA5, 8'hFF, 8'd0);
        wait_idle(100, "rmid");
        compared++;
        if (match_count !== 8'd3 || acc_q.size() != 4 || n_done != 1) begin
            $display("FAIL rmid_rerun: cnt=%0d reads=%0d done=%0d want 3 4 1",
                     match_count, acc_q.size(), n_done);
            mismatched++;
        end
    endtask

    task automatic test_busy_start();
        clear_mon();
        do_start(8'h10, 8'd4, 8'hA5, 8'hFF, 8'd0);
        @(negedge clk);
        base_addr = 8'h80;
        length = 8'd1;
        pattern = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100, "busy_start");
        compared++;
        if (acc_q.size() != 4 || acc_q[3] !== 8'h13) begin
            $display("FAIL busy_start_addr: reads=%0d last=%h want 4 13",
                     acc_q.size(), acc_q[3]);
            mismatched++;
        end
        compared++;
        if (match_count !== 8'd3 || n_done != 1) begin
            $display("FAIL busy_start_cnt: cnt=%0d done=%0d want 3 1",
                     match_count, n_done);
            mismatched++;
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        ready_delay = 0;
        valid_delay = 0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = 8'h00;
        length = 8'h00;
        pattern = 8'h00;
        mask = 8'h00;
        match_limit = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h00;
        mem[8'h12] = 8'hA5;
        mem[8'h13] = 8'hA5;
        clear_mon();
        test_reset();
        test_basic();
        test_limit();
        test_empty();
        test_wrap_stall();
        test_abort();
        test_reset_mid();
        test_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
